// File: rtl/mc_pkg.sv
// mc_pkg: shared definitions for the multicycle MIPS-style control unit.
// Holds the FSM state encoding, opcode and funct constants, ALU control codes
// and the ALU operand-B / PC-source mux encodings.
package mc_pkg;

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_EXEC_R    = 4'd2,
    S_EXEC_I    = 4'd3,
    S_ALU_WB    = 4'd4,
    S_MEM_ADDR  = 4'd5,
    S_MEM_READ  = 4'd6,
    S_MEM_WB    = 4'd7,
    S_MEM_WRITE = 4'd8,
    S_BRANCH    = 4'd9,
    S_JUMP      = 4'd10
  } state_e;

  // Opcodes (IR[31:26])
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;

  // R-type funct codes (IR[5:0])
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  // ALU control codes
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  // ALU operand B select
  localparam logic [1:0] SRC_B_RT    = 2'b00;
  localparam logic [1:0] SRC_B_FOUR  = 2'b01;
  localparam logic [1:0] SRC_B_IMM   = 2'b10;
  localparam logic [1:0] SRC_B_IMMSH = 2'b11;

  // PC source select
  localparam logic [1:0] PC_SRC_ALU    = 2'b00;
  localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

  function automatic logic is_imm_op(input logic [5:0] op);
    return (op == OP_ADDI) || (op == OP_ANDI) || (op == OP_ORI) || (op == OP_SLTI);
  endfunction

endpackage

// File: rtl/mc_alu_decode.sv
// mc_alu_decode: combinational instruction classifier.
// Ports:
//   opcode   in  [5:0]  IR[31:26]
//   funct    in  [5:0]  IR[5:0]
//   alu_ctrl out [2:0]  ALU operation for the execute step of this instruction
//   legal    out        1 when opcode (and funct, for R-type) is supported
module mc_alu_decode
  import mc_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output logic [2:0] alu_ctrl,
  output logic       legal
);

  always_comb begin
    alu_ctrl = ALU_ADD;
    legal    = 1'b1;
    case (opcode)
      OP_RTYPE: begin
        case (funct)
          FN_ADD:  alu_ctrl = ALU_ADD;
          FN_SUB:  alu_ctrl = ALU_SUB;
          FN_AND:  alu_ctrl = ALU_AND;
          FN_OR:   alu_ctrl = ALU_OR;
          FN_SLT:  alu_ctrl = ALU_SLT;
          default: legal    = 1'b0;
        endcase
      end
      OP_ADDI: alu_ctrl = ALU_ADD;
      OP_ANDI: alu_ctrl = ALU_AND;
      OP_ORI:  alu_ctrl = ALU_OR;
      OP_SLTI: alu_ctrl = ALU_SLT;
      // Memory, branch and jump are legal; their ALU ops come from the FSM.
      OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_J: alu_ctrl = ALU_ADD;
      default: legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// multicycle_control: sequencing FSM for a multicycle MIPS-style datapath.
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   opCode, funct          instruction fields from the IR (stable after FETCH)
//   zero                   ALU zero flag of the current cycle
//   mem_ready              memory completes the current access this cycle
//   pc_write, ir_write, reg_write, mem_read, mem_write   write enables
//   iord, alu_src_a, alu_src_b, pc_src, reg_dst, mem_to_reg   mux selects
//   alu_ctrl               ALU operation
//   done / illegal         one-cycle retire / decode-fault pulses
//   state                  current FSM state code (debug visibility)
// Memory handshake: mem_read or mem_write is a request held until the cycle
// in which mem_ready is 1; that cycle completes the access and the FSM moves
// on. mem_ready is ignored in every state that issues no request.
module multicycle_control
  import mc_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opCode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       ir_write,
  output logic       reg_write,
  output logic       mem_read,
  output logic       mem_write,
  output logic       iord,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] pc_src,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic [2:0] alu_ctrl,
  output logic       done,
  output logic       illegal,
  output logic [3:0] state
);

  state_e     state_q, state_d;
  logic [2:0] dec_alu_ctrl;
  logic       dec_legal;

  mc_alu_decode u_alu_decode (
    .opcode   (opCode),
    .funct    (funct),
    .alu_ctrl (dec_alu_ctrl),
    .legal    (dec_legal)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  assign state = state_q;

  always_comb begin
    state_d    = state_q;
    pc_write   = 1'b0;
    ir_write   = 1'b0;
    reg_write  = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    iord       = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = SRC_B_RT;
    pc_src     = PC_SRC_ALU;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    alu_ctrl   = ALU_AND;
    done       = 1'b0;
    illegal    = 1'b0;

    case (state_q)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = SRC_B_FOUR;
        alu_ctrl  = ALU_ADD;
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = S_DECODE;
        end
      end
      S_DECODE: begin
        // Precompute the branch target into ALUOut.
        alu_src_b = SRC_B_IMMSH;
        alu_ctrl  = ALU_ADD;
        if (!dec_legal) begin
          illegal = 1'b1;
          state_d = S_FETCH;
        end else if (opCode == OP_RTYPE) begin
          state_d = S_EXEC_R;
        end else if (is_imm_op(opCode)) begin
          state_d = S_EXEC_I;
        end else if (opCode == OP_LW || opCode == OP_SW) begin
          state_d = S_MEM_ADDR;
        end else if (opCode == OP_BEQ || opCode == OP_BNE) begin
          state_d = S_BRANCH;
        end else begin
          state_d = S_JUMP;
        end
      end
      S_EXEC_R: begin
        alu_src_a = 1'b1;
        alu_src_b = SRC_B_RT;
        alu_ctrl  = dec_alu_ctrl;
        state_d   = S_ALU_WB;
      end
      S_EXEC_I: begin
        alu_src_a = 1'b1;
        alu_src_b = SRC_B_IMM;
        alu_ctrl  = dec_alu_ctrl;
        state_d   = S_ALU_WB;
      end
      S_ALU_WB: begin
        reg_write = 1'b1;
        reg_dst   = (opCode == OP_RTYPE);
        done      = 1'b1;
        state_d   = S_FETCH;
      end
      S_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRC_B_IMM;
        alu_ctrl  = ALU_ADD;
        state_d   = (opCode == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
      end
      S_MEM_READ: begin
        mem_read = 1'b1;
        iord     = 1'b1;
        if (mem_ready) state_d = S_MEM_WB;
      end
      S_MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        done       = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEM_WRITE: begin
        mem_write = 1'b1;
        iord      = 1'b1;
        if (mem_ready) begin
          done    = 1'b1;
          state_d = S_FETCH;
        end
      end
      S_BRANCH: begin
        alu_src_a = 1'b1;
        alu_src_b = SRC_B_RT;
        alu_ctrl  = ALU_SUB;
        pc_src    = PC_SRC_ALUOUT;
        pc_write  = (opCode == OP_BNE) ? ~zero : zero;
        done      = 1'b1;
        state_d   = S_FETCH;
      end
      S_JUMP: begin
        pc_src   = PC_SRC_JUMP;
        pc_write = 1'b1;
        done     = 1'b1;
        state_d  = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase

    // The state register is already forced to FETCH by reset, but FETCH
    // issues a read; squash every side effect while reset is held.
    if (!rst_n) begin
      pc_write  = 1'b0;
      ir_write  = 1'b0;
      reg_write = 1'b0;
      mem_read  = 1'b0;
      mem_write = 1'b0;
      done      = 1'b0;
      illegal   = 1'b0;
    end
  end

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 SHALL have port clk, input, 1, sole clock; all state changes occur on its rising edge.
REQ-002 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-003 SHALL have ports opCode (input, 6, IR[31:26]) and funct (input, 6, IR[5:0]), sampled from the instruction register.
REQ-004 SHALL have port zero, input, 1, ALU zero flag from the current cycle.
REQ-005 SHALL have port mem_ready, input, 1; memory has completed the current read or write this cycle.
REQ-006 SHALL have write-enable outputs, each 1 bit: pc_write, ir_write, reg_write, mem_read, mem_write.
REQ-007 SHALL have mux-select outputs:
- iord, 1 (0=PC, 1=ALUOut address)
- alu_src_a, 1 (0=PC, 1=rs)
- alu_src_b, 2 (00=rt, 01=const 4, 10=sign-ext imm, 11=sign-ext imm<<2)
- pc_src, 2 (00=ALU result, 01=ALUOut, 10=jump target)
- reg_dst, 1 (1=rd)
- mem_to_reg, 1
REQ-008 SHALL have output alu_ctrl, 3: 010 add, 110 sub, 000 and, 001 or, 111 slt.
REQ-009 SHALL have status outputs done (1, instruction retire pulse), illegal (1, decode-fault pulse) and state (4, current state code).

Function
REQ-010 SHALL implement FSM states FETCH, DECODE, EXEC_R, EXEC_I, ALU_WB, MEM_ADDR, MEM_READ, MEM_WB, MEM_WRITE, BRANCH and JUMP.
REQ-011 SHALL drive every output not listed for a state to 0 in that state.
REQ-012 FETCH:
- Drive mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, alu_ctrl=010, pc_src=00.
- Assert ir_write=1 and pc_write=1 only when mem_ready=1, then go to DECODE; otherwise hold with no writes.
REQ-013 DECODE:
- Drive alu_src_a=0, alu_src_b=11, alu_ctrl=010 (branch target).
- Next state: R-type to EXEC_R; addi/andi/ori/slti (001000/001100/001101/001010) to EXEC_I; lw (100011)/sw (101011) to MEM_ADDR; beq (000100)/bne (000101) to BRANCH; j (000010) to JUMP.
REQ-014 Illegal opcode, or R-type with funct outside {100000,100010,100100,100101,101010}: SHALL pulse illegal=1 in DECODE, return to FETCH, and assert no writes.
REQ-015 EXEC_R SHALL drive alu_src_a=1, alu_src_b=00 and alu_ctrl from funct (add 010, sub 110, and 000, or 001, slt 111), then go to ALU_WB.
REQ-016 EXEC_I SHALL drive alu_src_a=1, alu_src_b=10 and alu_ctrl (addi 010, andi 000, ori 001, slti 111), then go to ALU_WB.
REQ-017 ALU_WB SHALL drive reg_write=1, mem_to_reg=0, reg_dst=1 for R-type and 0 for immediate ops, and done=1, then go to FETCH.
REQ-018 MEM_ADDR SHALL drive alu_src_a=1, alu_src_b=10, alu_ctrl=010, then go to MEM_READ for lw or MEM_WRITE for sw.
REQ-019 MEM_READ SHALL drive mem_read=1, iord=1 and hold until mem_ready=1, then go to MEM_WB.
REQ-019a MEM_WB SHALL drive reg_write=1, mem_to_reg=1, reg_dst=0, done=1, then go to FETCH.
REQ-020 MEM_WRITE SHALL drive mem_write=1, iord=1 and hold until mem_ready=1; on that cycle it SHALL drive done=1 and go to FETCH.
REQ-021 BRANCH SHALL drive alu_src_a=1, alu_src_b=00, alu_ctrl=110, pc_src=01, done=1, pc_write=zero for beq and pc_write=~zero for bne, then go to FETCH.
REQ-022 JUMP SHALL drive pc_src=10, pc_write=1, done=1, then go to FETCH.
REQ-023 Latency with mem_ready held 1 SHALL be: R/I-type 4 cycles, lw 5, sw 4, branch 3, j 3; each cycle of mem_ready=0 in FETCH, MEM_READ or MEM_WRITE adds exactly one cycle.
REQ-024 done and illegal SHALL never be asserted in the same cycle, and each SHALL assert for at most one cycle per instruction.

Reset
REQ-025 rst_n low SHALL force state=FETCH asynchronously.
REQ-026 While rst_n is low, all write enables, done and illegal SHALL be 0, including mid-instruction; selects are don't-care.
REQ-027 The first rising edge of clk with rst_n high SHALL evaluate FETCH normally.

Structure
REQ-028 Package mc_pkg SHALL hold the state encoding, opcode/funct constants, ALU code constants and alu_src_b/pc_src encodings.
REQ-029 Sub-module mc_alu_decode SHALL map opCode and funct to alu_ctrl and a legal flag, combinationally; the FSM SHALL contain all sequencing.

Verification
REQ-030 Reset, then add (op 000000, funct 100000), mem_ready=1 -> states FETCH, DECODE, EXEC_R, ALU_WB; alu_ctrl=010 in EXEC_R; reg_write=1, reg_dst=1, done=1 in cycle 4.
REQ-031 lw with mem_ready=0 for 3 cycles in MEM_READ -> mem_read=1, iord=1 held; MEM_WB gives reg_write=1, mem_to_reg=1; total 8 cycles.
REQ-032 beq with zero=1 -> pc_write=1, pc_src=01 in BRANCH; beq with zero=0 -> pc_write=0; bne with zero=0 -> pc_write=1.
REQ-033 opCode 111111, and separately R-type funct 000111 -> illegal=1 in DECODE, next state FETCH, no enable asserted.
REQ-034 rst_n dropped during MEM_WRITE -> mem_write=0 immediately; after release, FETCH with ir_write gated by mem_ready.
REQ-035 j (000010) -> pc_src=10, pc_write=1, done=1 on cycle 3; the next instruction fetch begins on cycle 4.
